rca_seq_adder: RTL
==================

Name: rca_seq_adder

Overview:
- Multi-cycle wide adder built around the existing 4-bit ripple_carry_adder (ports a, b, cin, sum, cout).
- Latches WIDTH-bit operands through a valid/ready handshake.
- Feeds one 4-bit slice per cycle into the adder, LSB slice first, and loops the adder's cout back as the next slice's cin.
- Presents the full WIDTH-bit sum and final carry through an output valid/ready handshake.
- Sits directly upstream of, and consumes the output of, the 4-bit adder.

Parameters:
- WIDTH, 16, operand/sum width; must be a multiple of SLICE and at least SLICE.
- SLICE, 4, adder slice width; fixed by ripple_carry_adder and not overridden.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset; asynchronous, active-high
- in_valid  input  1  operands and cin valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry into slice 0
- out_valid  output  1  sum/cout valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  registered result
- cout  output  1  carry out of the top slice
- busy  output  1  high in ADD or DONE

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, slice index=0, carry register=0.
  - sum=0, cout=0, out_valid=0, busy=0, in_ready=1 once rst deasserts.
  - Reset during ADD or DONE abandons the operation; no result is ever emitted.
- FSM states: IDLE, ADD, DONE. NSLICE = WIDTH/SLICE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a, b, cin into operand/carry registers; clear sum register; index=0; go to ADD.
- ADD:
  - in_ready=0.
  - Each cycle: adder.a=a_reg[index slice], adder.b=b_reg[index slice], adder.cin=carry register.
  - At the clock edge: sum[index slice] <= adder.sum; carry register <= adder.cout; index <= index+1.
  - On the edge that processes index==NSLICE-1: cout <= adder.cout; go to DONE.
- DONE:
  - out_valid=1. sum and cout are held stable until out_ready.
  - On out_ready: out_valid drops next cycle; go to IDLE.
  - No acceptance in the same cycle as out_ready; the next accept is possible one cycle later.
- Latency: out_valid rises exactly NSLICE cycles after the accepting edge (4 cycles at WIDTH=16). Throughput is one result per NSLICE+2 cycles with out_ready held high.
- Inputs a, b, cin, in_valid are ignored outside IDLE; changing them mid-operation has no effect.
- out_ready is ignored outside DONE.
- Arithmetic is unsigned modulo 2^WIDTH; {cout,sum} = a+b+cin exactly.
- The carry register never wraps across operations; it is reloaded from cin on every accept.

Optional Feature:
- Macro: RCA_SEQ_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit).
  - ovf is registered in DONE as (a_reg[WIDTH-1]==b_reg[WIDTH-1]) && (sum[WIDTH-1]!=a_reg[WIDTH-1]), i.e. two's-complement overflow.
  - Reset value 0; valid only while out_valid=1; held with sum.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package rca_seq_pkg holds:
  - the state typedef (IDLE, ADD, DONE),
  - the constant SLICE=4,
  - a function computing NSLICE and the index width (clog2 of NSLICE, minimum 1).
- Sub-module: the existing ripple_carry_adder, instantiated once as the slice datapath. No other sub-module is needed.

Test Plan:
- Basic: a=0x1234, b=0x0FFF, cin=0 -> sum=0x2233, cout=0; out_valid rises 4 cycles after accept.
- Full ripple: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1. Also a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, with carry propagating through all 4 slices.
- Backpressure: result of 0x00FF+0x0001 (sum=0x0100) with out_ready=0 for 5 cycles -> out_valid, sum, cout held stable, in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
- Mid-op input change: accept 0x0003+0x0004, then drive a=0xFFFF, b=0xFFFF, in_valid=1 during ADD -> sum=0x0007, cout=0; second operand pair not accepted until in_ready=1.
- Reset mid-ADD: assert rst at slice index 2 -> out_valid=0, busy=0 immediately (async); after release, 0x0001+0x0001 -> sum=0x0002, cout=0.
- RCA_SEQ_OVF_EN defined: 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1. Also 0x8000+0x8000 -> sum=0x0000, cout=1, ovf=1.

Source files
------------

// File: rtl/rca_seq_pkg.sv
// rca_seq_pkg: shared definitions for the sequential ripple-carry adder.
//   state_t   - FSM state encoding (IDLE, ADD, DONE)
//   SLICE     - width of one adder slice, fixed by ripple_carry_adder
//   nslice    - number of slices needed for a given operand width
//   idx_width - width of the slice index register (at least 1 bit)
package rca_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE = 4;

  function automatic int nslice(input int width);
    return width / SLICE;
  endfunction

  // A single-slice build still needs a 1-bit index so the register exists.
  function automatic int idx_width(input int width);
    int n;
    n = width / SLICE;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder: 4-bit combinational ripple-carry adder.
// Ports:
//   a, b  - 4-bit addends
//   cin   - carry in
//   sum   - 4-bit sum
//   cout  - carry out of bit 3
module ripple_carry_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] carry;

  // Chain of full adders, carry rippling from bit 0 upward.
  always_comb begin
    carry    = 5'd0;
    sum      = 4'd0;
    carry[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[4];
  end

endmodule

// File: rtl/rca_seq_adder.sv
// rca_seq_adder: multi-cycle WIDTH-bit adder that streams one 4-bit slice per
// cycle (LSB first) through a single ripple_carry_adder, feeding each slice's
// carry out back in as the next slice's carry in.
// Ports:
//   clk, rst             - rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready  - operand handshake (a, b, cin sampled on accept)
//   out_valid / out_ready- result handshake (sum, cout held until taken)
//   busy                 - high while an operation is in flight (ADD or DONE)
//   ovf                  - two's-complement overflow, present only when the
//                          RCA_SEQ_OVF_EN macro is defined
module rca_seq_adder
  import rca_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef RCA_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = nslice(WIDTH);
  localparam int IDXW   = idx_width(WIDTH);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  state_t            state;
  state_t            state_nxt;
  logic [IDXW-1:0]   idx;
  logic              carry;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;
  logic              accept;
  logic              step;
  logic              last;

  logic [SLICE-1:0]  add_a;
  logic [SLICE-1:0]  add_b;
  logic [SLICE-1:0]  add_sum;
  logic              add_cout;

  ripple_carry_adder u_slice (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Select the operand slice currently being added.
  always_comb begin
    add_a = a_reg[int'(idx) * SLICE +: SLICE];
    add_b = b_reg[int'(idx) * SLICE +: SLICE];
  end

  // Next-state logic and per-cycle datapath enables.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept    = 1'b1;
          state_nxt = ADD;
        end else begin
          state_nxt = IDLE;
        end
      end
      ADD: begin
        step = 1'b1;
        if (idx == LAST_IDX) begin
          last      = 1'b1;
          state_nxt = DONE;
        end else begin
          state_nxt = ADD;
        end
      end
      DONE: begin
        // Returning to IDLE first means no accept can share the release cycle.
        if (out_ready) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DONE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake/status outputs, registered from the next state so they change
  // in the same cycle as the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      busy      <= (state_nxt != IDLE);
      out_valid <= (state_nxt == DONE);
    end
  end

  // Operand capture, slice-by-slice sum accumulation and carry loop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_reg <= a;
      b_reg <= b;
      carry <= cin;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (step) begin
      sum[int'(idx) * SLICE +: SLICE] <= add_sum;
      carry <= add_cout;
      idx   <= idx + IDXW'(1);
      if (last) begin
        cout <= add_cout;
      end
    end
  end

`ifdef RCA_SEQ_OVF_EN
  // Overflow is judged on the sign bit produced by the final slice, which is
  // being written into sum on this same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (accept) begin
      ovf <= 1'b0;
    end else if (step && last) begin
      ovf <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
             (add_sum[SLICE-1] != a_reg[WIDTH-1]);
    end
  end
`endif

endmodule
